// File: rtl/smem_pkg.sv
// Shared types and defaults for the screen-memory arbiter slice.
package smem_pkg;
   localparam int unsigned NLOC_DEFAULT  = 1200;
   localparam int unsigned DBITS_DEFAULT = 4;
   localparam int unsigned FIFO_DEPTH    = 4;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_FILL = 1'b1
   } fill_state_t;
endpackage

// File: rtl/smem_arbiter_if.sv
// Bundle of display, CPU store, block fill and memory-port signals around the arbiter.
interface smem_arbiter_if #(
   parameter int unsigned Nloc  = smem_pkg::NLOC_DEFAULT,
   parameter int unsigned Dbits = smem_pkg::DBITS_DEFAULT
);
   localparam int unsigned AW = $clog2(Nloc);

   logic             vga_req;
   logic [AW-1:0]    vga_addr;
   logic [Dbits-1:0] vga_data;

   logic             cpu_wr;
   logic [AW-1:0]    cpu_addr;
   logic [Dbits-1:0] cpu_wdata;
   logic             cpu_wr_ready;

   logic             fill_start;
   logic [AW-1:0]    fill_base;
   logic [AW-1:0]    fill_len;
   logic [Dbits-1:0] fill_val;
   logic             fill_busy;

   logic [AW-1:0]    mem_addr;
   logic             mem_we;
   logic [Dbits-1:0] mem_wdata;
   logic [Dbits-1:0] mem_rdata;

   modport slave (
      input  vga_req, vga_addr, cpu_wr, cpu_addr, cpu_wdata,
      input  fill_start, fill_base, fill_len, fill_val, mem_rdata,
      output vga_data, cpu_wr_ready, fill_busy, mem_addr, mem_we, mem_wdata
   );

   modport master (
      output vga_req, vga_addr, cpu_wr, cpu_addr, cpu_wdata,
      output fill_start, fill_base, fill_len, fill_val, mem_rdata,
      input  vga_data, cpu_wr_ready, fill_busy, mem_addr, mem_we, mem_wdata
   );
endinterface

// File: rtl/smem_wfifo.sv
// Small circular write FIFO; push is ignored when full, pop is ignored when empty.
module smem_wfifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [WIDTH-1:0] i_wdata,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_full,
   output logic             o_empty
);
   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wptr;
   logic [PW-1:0]    r_rptr;
   logic [CW-1:0]    r_count;
   logic             w_push;
   logic             w_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;
   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_rdata = r_mem[r_rptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= ptr_inc(r_wptr);
         if (w_pop)  r_rptr <= ptr_inc(r_rptr);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage needs no reset: occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= i_wdata;
   end
endmodule

// File: rtl/smem_arbiter.sv
// Single-port screen memory arbiter: display reads beat queued CPU stores, which beat block fill.
module smem_arbiter
   import smem_pkg::*;
#(
   parameter int unsigned Nloc  = NLOC_DEFAULT,
   parameter int unsigned Dbits = DBITS_DEFAULT
) (
   input  logic           clk,
   input  logic           reset,
   smem_arbiter_if.slave  bus
);
   localparam int unsigned AW = $clog2(Nloc);
   localparam int unsigned FW = AW + Dbits;

   fill_state_t      r_state;
   logic [AW-1:0]    r_fill_addr;
   logic [AW-1:0]    r_fill_left;
   logic [Dbits-1:0] r_fill_val;
   logic [Dbits-1:0] r_vga_data;

   logic [FW-1:0]    w_head;
   logic [AW-1:0]    w_head_addr;
   logic [Dbits-1:0] w_head_data;
   logic             w_full;
   logic             w_empty;
   logic             w_fifo_gnt;
   logic             w_fill_gnt;

   smem_wfifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (FW)
   ) u_wfifo (
      .clk     (clk),
      .rst     (reset),
      .i_push  (bus.cpu_wr && !w_full),
      .i_pop   (w_fifo_gnt),
      .i_wdata ({bus.cpu_addr, bus.cpu_wdata}),
      .o_rdata (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign w_head_addr = w_head[FW-1:Dbits];
   assign w_head_data = w_head[Dbits-1:0];

   // Fixed priority: display, then FIFO head, then fill engine.
   assign w_fifo_gnt = !bus.vga_req && !w_empty;
   assign w_fill_gnt = !bus.vga_req && w_empty && (r_state == ST_FILL);

   assign bus.mem_we    = w_fifo_gnt || w_fill_gnt;
   assign bus.mem_addr  = w_fifo_gnt ? w_head_addr :
                          w_fill_gnt ? r_fill_addr : bus.vga_addr;
   assign bus.mem_wdata = w_fifo_gnt ? w_head_data :
                          w_fill_gnt ? r_fill_val  : '0;

   assign bus.cpu_wr_ready = !w_full;
   assign bus.fill_busy    = (r_state == ST_FILL);
   assign bus.vga_data     = r_vga_data;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_vga_data <= '0;
      end else if (bus.vga_req) begin
         r_vga_data <= bus.mem_rdata;
      end
   end

   // Fill engine holds its position whenever it is not granted.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_fill_addr <= '0;
         r_fill_left <= '0;
         r_fill_val  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.fill_start && (bus.fill_len != '0)) begin
                  r_state     <= ST_FILL;
                  r_fill_addr <= bus.fill_base;
                  r_fill_left <= bus.fill_len;
                  r_fill_val  <= bus.fill_val;
               end
            end
            ST_FILL: begin
               if (w_fill_gnt) begin
                  r_fill_addr <= (r_fill_addr == AW'(Nloc - 1)) ? '0 : r_fill_addr + AW'(1);
                  r_fill_left <= r_fill_left - AW'(1);
                  if (r_fill_left == AW'(1)) r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_smem_arbiter.sv
// Directed bench for smem_arbiter with a behavioural single-port screen memory.
module tb_smem_arbiter;
   localparam int unsigned NLOC  = 1200;
   localparam int unsigned DBITS = 4;
   localparam int unsigned AW    = $clog2(NLOC);

   logic clk = 1'b0;
   logic reset;
   logic preload;

   smem_arbiter_if #(.Nloc(NLOC), .Dbits(DBITS)) bus ();

   smem_arbiter #(.Nloc(NLOC), .Dbits(DBITS)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   logic [DBITS-1:0] mem [NLOC];
   logic [AW-1:0]    log_addr [$];
   logic [DBITS-1:0] log_data [$];

   assign bus.mem_rdata = mem[bus.mem_addr];

   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < int'(NLOC); i++) mem[i] <= '0;
         mem[5] <= 4'd3;
      end else if (bus.mem_we) begin
         mem[bus.mem_addr] <= bus.mem_wdata;
         log_addr.push_back(bus.mem_addr);
         log_data.push_back(bus.mem_wdata);
      end
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   int base_i;
   int exp_addr [4] = '{1198, 1199, 0, 1};

   initial begin
      reset          = 1'b1;
      preload        = 1'b1;
      bus.vga_req    = 1'b0;
      bus.vga_addr   = '0;
      bus.cpu_wr     = 1'b0;
      bus.cpu_addr   = '0;
      bus.cpu_wdata  = '0;
      bus.fill_start = 1'b0;
      bus.fill_base  = '0;
      bus.fill_len   = '0;
      bus.fill_val   = '0;
      tick();
      tick();
      preload = 1'b0;
      check("rst_ready", 32'(bus.cpu_wr_ready), 1);
      check("rst_busy", 32'(bus.fill_busy), 0);
      check("rst_we", 32'(bus.mem_we), 0);
      check("rst_vga_data", 32'(bus.vga_data), 0);
      reset = 1'b0;
      tick();

      // Display read with one cycle latency
      bus.vga_req  = 1'b1;
      bus.vga_addr = AW'(5);
      #1;
      check("vga_we", 32'(bus.mem_we), 0);
      check("vga_addr", 32'(bus.mem_addr), 5);
      tick();
      check("vga_data", 32'(bus.vga_data), 3);
      bus.vga_req  = 1'b0;
      bus.vga_addr = AW'(7);
      tick();
      check("vga_hold", 32'(bus.vga_data), 3);
      #1;
      check("idle_addr", 32'(bus.mem_addr), 7);

      // Five stores while display holds the port
      bus.vga_req  = 1'b1;
      bus.vga_addr = '0;
      base_i = log_addr.size();
      for (int i = 0; i < 5; i++) begin
         bus.cpu_wr    = 1'b1;
         bus.cpu_addr  = AW'(100 + i);
         bus.cpu_wdata = DBITS'(i + 1);
         #1;
         check($sformatf("push_ready%0d", i), 32'(bus.cpu_wr_ready), (i < 4) ? 1 : 0);
         tick();
      end
      bus.cpu_wr = 1'b0;
      check("blocked_writes", 32'(log_addr.size() - base_i), 0);

      // Drain in push order
      bus.vga_req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         check($sformatf("drain_we%0d", i), 32'(bus.mem_we), 1);
         check($sformatf("drain_addr%0d", i), 32'(bus.mem_addr), 32'(100 + i));
         check($sformatf("drain_data%0d", i), 32'(bus.mem_wdata), 32'(i + 1));
         tick();
      end
      check("drain_ready", 32'(bus.cpu_wr_ready), 1);
      check("drain_we_after", 32'(bus.mem_we), 0);
      check("dropped_fifth", 32'(mem[104]), 0);

      // Zero-length fill is ignored
      bus.fill_start = 1'b1;
      bus.fill_base  = AW'(50);
      bus.fill_len   = '0;
      bus.fill_val   = DBITS'(2);
      tick();
      bus.fill_start = 1'b0;
      check("len0_busy", 32'(bus.fill_busy), 0);

      // Wrapping fill without contention
      bus.fill_start = 1'b1;
      bus.fill_base  = AW'(1198);
      bus.fill_len   = AW'(4);
      bus.fill_val   = DBITS'(7);
      tick();
      bus.fill_start = 1'b0;
      check("wrap_busy", 32'(bus.fill_busy), 1);
      for (int i = 0; i < 4; i++) begin
         #1;
         check($sformatf("wrap_we%0d", i), 32'(bus.mem_we), 1);
         check($sformatf("wrap_addr%0d", i), 32'(bus.mem_addr), 32'(exp_addr[i]));
         check($sformatf("wrap_data%0d", i), 32'(bus.mem_wdata), 7);
         tick();
      end
      check("wrap_done", 32'(bus.fill_busy), 0);
      check("wrap_mem0", 32'(mem[0]), 7);
      check("wrap_mem2", 32'(mem[2]), 0);

      // Fill interleaved with display every other cycle; a second start is ignored
      bus.fill_start = 1'b1;
      bus.fill_base  = AW'(200);
      bus.fill_len   = AW'(10);
      bus.fill_val   = DBITS'(9);
      tick();
      bus.fill_start = 1'b0;
      base_i = log_addr.size();
      for (int c = 0; c < 20; c++) begin
         bus.vga_req  = (c % 2 == 0);
         bus.vga_addr = AW'(5);
         if (c == 3) begin
            bus.fill_start = 1'b1;
            bus.fill_base  = AW'(500);
            bus.fill_len   = AW'(3);
            bus.fill_val   = DBITS'(1);
         end else begin
            bus.fill_start = 1'b0;
         end
         #1;
         check($sformatf("ilv_we%0d", c), 32'(bus.mem_we), (c % 2 == 0) ? 0 : 1);
         tick();
      end
      bus.vga_req    = 1'b0;
      bus.fill_start = 1'b0;
      check("ilv_done", 32'(bus.fill_busy), 0);
      check("ilv_count", 32'(log_addr.size() - base_i), 10);
      for (int k = 0; k < 10 && base_i + k < log_addr.size(); k++) begin
         check($sformatf("ilv_addr%0d", k), 32'(log_addr[base_i + k]), 32'(200 + k));
         check($sformatf("ilv_data%0d", k), 32'(log_data[base_i + k]), 9);
      end
      check("ilv_ignored", 32'(mem[500]), 0);
      check("ilv_vga_data", 32'(bus.vga_data), 3);

      // Reset on the third fill cycle aborts the fill
      bus.fill_start = 1'b1;
      bus.fill_base  = AW'(300);
      bus.fill_len   = AW'(8);
      bus.fill_val   = DBITS'(4);
      tick();
      bus.fill_start = 1'b0;
      base_i = log_addr.size();
      tick();
      tick();
      reset = 1'b1;
      #1;
      check("abort_busy", 32'(bus.fill_busy), 0);
      check("abort_we", 32'(bus.mem_we), 0);
      tick();
      reset = 1'b0;
      repeat (5) tick();
      check("abort_count", 32'(log_addr.size() - base_i), 2);
      check("abort_mem301", 32'(mem[301]), 4);
      check("abort_mem302", 32'(mem[302]), 0);

      // Reset empties a full FIFO
      bus.vga_req = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.cpu_wr    = 1'b1;
         bus.cpu_addr  = AW'(400 + i);
         bus.cpu_wdata = DBITS'(6);
         tick();
      end
      bus.cpu_wr = 1'b0;
      check("full_ready", 32'(bus.cpu_wr_ready), 0);
      reset = 1'b1;
      #1;
      check("rst_fifo_ready", 32'(bus.cpu_wr_ready), 1);
      tick();
      reset       = 1'b0;
      bus.vga_req = 1'b0;
      base_i = log_addr.size();
      repeat (5) tick();
      check("rst_fifo_nowrite", 32'(log_addr.size() - base_i), 0);
      check("rst_fifo_mem400", 32'(mem[400]), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
